// File: rtl/isp_pkg.sv
// Shared ISP pipeline definitions: default pixel width, pixel type and the
// state encoding of the window feeder FSM.
package isp_pkg;

    localparam int PIX_W_DEF = 8;

    typedef logic [PIX_W_DEF-1:0] pixel_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/conv_line_buffer.sv
// Stack of ROWS image lines addressed by column; a write pushes the new pixel
// into row 0 and moves every older row down by one at the same column.
module conv_line_buffer #(
    parameter int ROWS  = 2,
    parameter int IMG_W = 64,
    parameter int PIX_W = 8,
    localparam int CW   = $clog2(IMG_W)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [CW-1:0]         col,
    input  logic [PIX_W-1:0]      din,
    output logic [ROWS*PIX_W-1:0] column
);

    logic [PIX_W-1:0] mem [ROWS][IMG_W];

    // NOTE: the storage has no reset so it maps onto RAM; stale contents are never emitted.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[0][col] <= din;
            for (int k = 1; k < ROWS; k++) begin
                mem[k][col] <= mem[k-1][col];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < ROWS; k++) begin
            column[k*PIX_W +: PIX_W] = mem[k][col];
        end
    end

endmodule

// File: rtl/conv_window_feeder.sv
// Turns a raster pixel stream into SIZE x SIZE windows (no border padding),
// one per valid output position, with a single registered output stage.
module conv_window_feeder
    import isp_pkg::*;
#(
    parameter int SIZE  = 3,
    parameter int PIX_W = PIX_W_DEF,
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    localparam int XW   = $clog2(IMG_W),
    localparam int YW   = $clog2(IMG_H)
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PIX_W-1:0]           in_pixel,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SIZE*SIZE*PIX_W-1:0] out_window,
    output logic [XW-1:0]              out_x,
    output logic [YW-1:0]              out_y,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done
);

    localparam int HALF = SIZE / 2;

    logic [1:0]                 state;
    logic [XW-1:0]              col;
    logic [YW-1:0]              row;
    logic [PIX_W-1:0]           win      [SIZE][SIZE];
    logic [PIX_W-1:0]           win_next [SIZE][SIZE];
    logic [SIZE*SIZE*PIX_W-1:0] win_packed;
    logic [(SIZE-1)*PIX_W-1:0]  lb_col;
    logic                       accept;
    logic                       emit;
    logic                       last_pix;

    assign in_ready = (state == ST_RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign emit     = (col >= XW'(SIZE-1)) && (row >= YW'(SIZE-1));
    assign last_pix = (col == XW'(IMG_W-1)) && (row == YW'(IMG_H-1));
    assign busy     = (state == ST_RUN) || (state == ST_FLUSH);
    assign done     = (state == ST_DONE);

    conv_line_buffer #(
        .ROWS  (SIZE-1),
        .IMG_W (IMG_W),
        .PIX_W (PIX_W)
    ) u_line_buffer (
        .clk    (clk),
        .we     (accept),
        .col    (col),
        .din    (in_pixel),
        .column (lb_col)
    );

    // Row 0 of the window is the oldest line, i.e. the deepest line-buffer row.
    // NOTE: every element of win_next and win_packed is assigned on each pass, so no latch is inferred.
    always_comb begin
        win_packed = '0;
        for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE-1; c++) begin
                win_next[r][c] = win[r][c+1];
            end
        end
        for (int r = 0; r < SIZE-1; r++) begin
            win_next[r][SIZE-1] = lb_col[(SIZE-2-r)*PIX_W +: PIX_W];
        end
        win_next[SIZE-1][SIZE-1] = in_pixel;
        for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE; c++) begin
                win_packed[(r*SIZE+c)*PIX_W +: PIX_W] = win_next[r][c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            win <= win_next;
        end
    end

    // NOTE: sequential state uses <= so every flop samples its pre-edge inputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= ST_IDLE;
            col   <= '0;
            row   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        col   <= '0;
                        row   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        if (col == XW'(IMG_W-1)) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                        if (last_pix) begin
                            state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (!out_valid || out_ready) begin
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A new window may load in the same cycle the previous one is handed off.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            out_valid  <= 1'b0;
            out_window <= '0;
            out_x      <= '0;
            out_y      <= '0;
            out_last   <= 1'b0;
        end else if (accept && emit) begin
            out_valid  <= 1'b1;
            out_window <= win_packed;
            out_x      <= col - XW'(HALF);
            out_y      <= row - YW'(HALF);
            out_last   <= last_pix;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_window_feeder.sv
// Scoreboard bench: a 3x3/4x4 feeder and a 5x5/6x6 feeder checked against a
// window model computed directly from the frame image.
module tb_conv_window_feeder;
    import isp_pkg::*;

    localparam int AS = 3, AW = 4, AH = 4;
    localparam int BS = 5, BW = 6, BH = 6;
    localparam int WMAX = 200;

    typedef struct {
        logic [WMAX-1:0] win;
        int              x;
        int              y;
        bit              last;
    } exp_t;

    logic   clk = 1'b0;
    logic   n_rst = 1'b0;
    logic   a_start = 1'b0, b_start = 1'b0;
    logic   in_valid = 1'b0;
    logic   out_ready = 1'b1;
    pixel_t in_pixel = '0;

    logic                 a_in_ready, a_out_valid, a_out_last, a_busy, a_done;
    logic [AS*AS*8-1:0]   a_out_window;
    logic [1:0]           a_out_x, a_out_y;
    logic                 b_in_ready, b_out_valid, b_out_last, b_busy, b_done;
    logic [BS*BS*8-1:0]   b_out_window;
    logic [2:0]           b_out_x, b_out_y;

    int              passed = 0;
    int              total  = 0;
    exp_t            qa[$];
    exp_t            qb[$];
    int              a_wins = 0, b_wins = 0, a_dones = 0, b_dones = 0;
    logic [WMAX-1:0] a_hist [64];
    logic [WMAX-1:0] b_hist [64];
    pixel_t          img [64];

    always #5 clk = ~clk;

    conv_window_feeder #(.SIZE(AS), .PIX_W(8), .IMG_W(AW), .IMG_H(AH)) dut_a (
        .clk(clk), .n_rst(n_rst), .start(a_start), .in_valid(in_valid),
        .in_ready(a_in_ready), .in_pixel(in_pixel), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_window(a_out_window), .out_x(a_out_x),
        .out_y(a_out_y), .out_last(a_out_last), .busy(a_busy), .done(a_done)
    );

    conv_window_feeder #(.SIZE(BS), .PIX_W(8), .IMG_W(BW), .IMG_H(BH)) dut_b (
        .clk(clk), .n_rst(n_rst), .start(b_start), .in_valid(in_valid),
        .in_ready(b_in_ready), .in_pixel(in_pixel), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_window(b_out_window), .out_x(b_out_x),
        .out_y(b_out_y), .out_last(b_out_last), .busy(b_busy), .done(b_done)
    );

    task automatic check(input string name, input logic [WMAX-1:0] got, input logic [WMAX-1:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got %0h, want %0h", name, got, want);
    endtask

    task automatic report_fail(input string what);
        total++;
        $display("FAIL %s", what);
    endtask

    // Reference model: every window position of the frame, straight from the image.
    task automatic model_frame(input bit sel, input int s, input int w, input int h);
        exp_t e;
        for (int y = s-1; y < h; y++) begin
            for (int x = s-1; x < w; x++) begin
                e.win = '0;
                for (int r = 0; r < s; r++)
                    for (int c = 0; c < s; c++)
                        e.win[(r*s+c)*8 +: 8] = img[(y-s+1+r)*w + (x-s+1+c)];
                e.x    = x - s/2;
                e.y    = y - s/2;
                e.last = (x == w-1) && (y == h-1);
                if (sel) qb.push_back(e);
                else     qa.push_back(e);
            end
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (a_done) a_dones++;
            if (b_done) b_dones++;
            if (a_out_valid && out_ready) begin
                a_hist[a_wins % 64] = WMAX'(a_out_window);
                a_wins++;
                if (qa.size() == 0) report_fail($sformatf("a_extra_window: got %0h, want none", a_out_window));
                else begin
                    e = qa.pop_front();
                    check("a_window", WMAX'(a_out_window), e.win);
                    check("a_out_x", WMAX'(a_out_x), WMAX'(e.x));
                    check("a_out_y", WMAX'(a_out_y), WMAX'(e.y));
                    check("a_out_last", WMAX'(a_out_last), WMAX'(e.last));
                end
            end
            if (b_out_valid && out_ready) begin
                b_hist[b_wins % 64] = WMAX'(b_out_window);
                b_wins++;
                if (qb.size() == 0) report_fail($sformatf("b_extra_window: got %0h, want none", b_out_window));
                else begin
                    e = qb.pop_front();
                    check("b_window", WMAX'(b_out_window), e.win);
                    check("b_out_x", WMAX'(b_out_x), WMAX'(e.x));
                    check("b_out_y", WMAX'(b_out_y), WMAX'(e.y));
                    check("b_out_last", WMAX'(b_out_last), WMAX'(e.last));
                end
            end
        end
    endtask

    // Called and returns at posedge+1. Feeds img[0..stop_after-1] into the selected DUT.
    task automatic feed(input bit sel, input int stop_after, input bit bubbles,
                        input bit rnd_ready, input int start_at);
        int idx = 0;
        int guard = 0;
        bit acc;
        while (idx < stop_after && guard < 4000) begin
            in_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            in_pixel = img[idx];
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            a_start = (!sel && idx == start_at);
            @(negedge clk);
            acc = in_valid && (sel ? b_in_ready : a_in_ready);
            @(posedge clk);
            #1;
            if (acc) idx++;
            guard++;
        end
        in_valid = 1'b0;
        a_start  = 1'b0;
        if (guard >= 4000) report_fail($sformatf("feed_timeout: accepted %0d, want %0d", idx, stop_after));
    endtask

    task automatic wait_done(input bit sel);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sel ? b_done : a_done) && n < 500);
        if (!(sel ? b_done : a_done)) report_fail($sformatf("done_timeout sel=%0d after %0d cycles", sel, n));
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) b_start = 1'b1;
        else     a_start = 1'b1;
        @(posedge clk);
        #1;
        a_start = 1'b0;
        b_start = 1'b0;
    endtask

    task automatic frame_checks(input bit sel, input int base_w, input int base_d, input int n_exp);
        if (sel) begin
            check("b_window_count", WMAX'(b_wins - base_w), WMAX'(n_exp));
            check("b_done_pulses", WMAX'(b_dones - base_d), WMAX'(1));
            check("b_busy_after", WMAX'(b_busy), WMAX'(0));
            check("b_queue_drained", WMAX'(qb.size()), WMAX'(0));
        end else begin
            check("a_window_count", WMAX'(a_wins - base_w), WMAX'(n_exp));
            check("a_done_pulses", WMAX'(a_dones - base_d), WMAX'(1));
            check("a_busy_after", WMAX'(a_busy), WMAX'(0));
            check("a_queue_drained", WMAX'(qa.size()), WMAX'(0));
        end
    endtask

    task automatic run_frame_a(input bit bubbles, input bit rnd_ready, input int start_at);
        int bw = a_wins;
        int bd = a_dones;
        model_frame(1'b0, AS, AW, AH);
        pulse_start(1'b0);
        feed(1'b0, AW*AH, bubbles, rnd_ready, start_at);
        out_ready = 1'b1;
        wait_done(1'b0);
        frame_checks(1'b0, bw, bd, (AW-AS+1)*(AH-AS+1));
    endtask

    task automatic ramp(input int n);
        for (int i = 0; i < n; i++) img[i] = pixel_t'(i);
    endtask

    initial begin
        int base;
        int n;
        exp_t head;
        logic [WMAX-1:0] w;

        fork
            monitor();
            begin
                #2_000_000;
                $display("FAIL watchdog: simulation did not finish");
                $fatal(1);
            end
        join_none

        // Reset state
        #12;
        check("rst_in_ready", WMAX'(a_in_ready), WMAX'(0));
        check("rst_out_valid", WMAX'(a_out_valid), WMAX'(0));
        check("rst_out_window", WMAX'(a_out_window), WMAX'(0));
        check("rst_out_xy", WMAX'({a_out_x, a_out_y}), WMAX'(0));
        check("rst_out_last", WMAX'(a_out_last), WMAX'(0));
        check("rst_busy_done", WMAX'({a_busy, a_done, b_busy, b_done}), WMAX'(0));
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        // Ramp frame with explicit first/last windows
        ramp(AW*AH);
        base = a_wins;
        run_frame_a(1'b0, 1'b0, -1);
        check("a_first_window", a_hist[base % 64], WMAX'(72'h0a0908_060504_020100));
        check("a_last_window", a_hist[(base+3) % 64], WMAX'(72'h0f0e0d_0b0a09_070605));

        // Backpressure: hold out_ready low while the first window waits
        base = a_wins;
        n = a_dones;
        out_ready = 1'b0;
        model_frame(1'b0, AS, AW, AH);
        pulse_start(1'b0);
        fork
            feed(1'b0, AW*AH, 1'b0, 1'b0, -1);
            begin
                int k = 0;
                do begin
                    @(negedge clk);
                    k++;
                end while (!a_out_valid && k < 100);
                if (!a_out_valid) report_fail("bp_no_window within 100 cycles");
                head = qa[0];
                repeat (5) begin
                    @(negedge clk);
                    check("bp_in_ready", WMAX'(a_in_ready), WMAX'(0));
                    check("bp_out_valid", WMAX'(a_out_valid), WMAX'(1));
                    check("bp_window_held", WMAX'(a_out_window), head.win);
                    check("bp_xy_held", WMAX'({a_out_x, a_out_y}), WMAX'({2'(head.x), 2'(head.y)}));
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_done(1'b0);
        frame_checks(1'b0, base, n, 4);

        // Bubbles on the ramp frame, then random pixels with random backpressure
        run_frame_a(1'b1, 1'b0, -1);
        repeat (3) begin
            for (int i = 0; i < AW*AH; i++) img[i] = pixel_t'($urandom);
            run_frame_a(1'b1, 1'b1, -1);
        end

        // Reset mid-frame after 7 accepted pixels
        ramp(AW*AH);
        pulse_start(1'b0);
        feed(1'b0, 7, 1'b0, 1'b0, -1);
        check("pre_rst_busy", WMAX'(a_busy), WMAX'(1));
        #2;
        n_rst = 1'b0;
        #1;
        check("mid_rst_in_ready", WMAX'(a_in_ready), WMAX'(0));
        check("mid_rst_busy", WMAX'(a_busy), WMAX'(0));
        check("mid_rst_outputs", WMAX'({a_out_valid, a_out_last, a_out_x, a_out_y}), WMAX'(0));
        check("mid_rst_window", WMAX'(a_out_window), WMAX'(0));
        qa.delete();
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        base = a_wins;
        run_frame_a(1'b0, 1'b0, -1);
        check("post_rst_first_window", a_hist[base % 64], WMAX'(72'h0a0908_060504_020100));

        // start during RUN is ignored; back-to-back frames match
        base = a_wins;
        run_frame_a(1'b0, 1'b0, 5);
        run_frame_a(1'b0, 1'b0, -1);
        for (int i = 0; i < 4; i++)
            check("b2b_same_output", a_hist[(base+4+i) % 64], a_hist[(base+i) % 64]);

        // 5x5 window over a 6x6 ramp
        ramp(BW*BH);
        base = b_wins;
        n = b_dones;
        model_frame(1'b1, BS, BW, BH);
        pulse_start(1'b1);
        feed(1'b1, BW*BH, 1'b1, 1'b0, -1);
        out_ready = 1'b1;
        wait_done(1'b1);
        frame_checks(1'b1, base, n, 4);
        w = b_hist[base % 64];
        check("b_first_elem0", WMAX'(w[7:0]), WMAX'(0));
        check("b_first_elem24", WMAX'(w[24*8 +: 8]), WMAX'(28));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
